demux1ton_reg: RTL
==================

# demux1toN_reg

Registered, parametrised 1-to-N demultiplexer with valid/ready flow control on the input and on each of N output channels. Each channel owns a one-deep holding register, so a stalled channel does not block traffic routed to other channels. Adds a broadcast mode and a sticky error flag for out-of-range selects. It is the sequential successor of the 4-way combinational `demux1to4` and sits between a single producer and N independent consumers.

## Interface
- `N`, 4: number of output channels, 2 to 16.
- `W`, 1: data width in bits, 1 to 32.
- `SW`, `$clog2(N)`: select width; derived, not overridden.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `i`  in  W  input data.
- `s`  in  SW  channel select, unicast mode.
- `bc`  in  1  broadcast: 1 writes `i` to all N channels; `s` is ignored.
- `in_valid`  in  1  producer offers `i`/`s`/`bc`.
- `in_ready`  out  1  block accepts this cycle.
- `d`  out  N*W  channel data; channel k is `d[k*W +: W]`.
- `d_valid`  out  N  channel k holds unconsumed data.
- `d_ready`  in  N  consumer k takes data.
- `err`  out  1  sticky flag: an out-of-range select was accepted.
- `err_clr`  in  1  clears `err`.

## Operation
- Per channel, `free[k] = !d_valid[k] || d_ready[k]`. The condition is combinational and allows a drain and a refill in the same cycle.
- `in_ready` is combinational:
  - 0 while `rst` is high.
  - In broadcast (`bc=1`): the AND of all `free[k]`.
  - In unicast with `s < N`: `free[s]`.
  - In unicast with `s >= N` (possible only when N is not a power of 2): 1.
- An input transfer occurs when `in_valid && in_ready`.
- Unicast transfer with `s < N`: the channel-s register loads `i` and sets `d_valid[s]=1` at the next edge.
- Broadcast transfer: all N registers load `i` and all `d_valid` bits are set at the next edge.
- Unicast transfer with `s >= N`: the word is dropped, no channel changes, and `err` goes to 1 at the next edge.
- Output transfer on channel k occurs when `d_valid[k] && d_ready[k]`:
  - `d_valid[k]` clears at the next edge unless the same cycle reloads the channel, in which case it stays 1 with the new data.
- `d` slices hold their last value after draining; they are not zeroed.
- `err_clr` clears `err` at the next edge. If a new error occurs in the same cycle, the set wins and `err` stays 1.
- Channels are independent. A full, stalled channel never affects `in_ready` for a unicast aimed at another channel.
- No ordering across channels. Per-channel order is inherent because each channel holds one entry.

## Timing
- Reset values: `d` = 0, `d_valid` = 0, `err` = 0, `in_ready` = 0 during reset.
- Reset mid-operation discards all held data. In-flight handshakes in the reset cycle are ignored.
- Latency: input accepted at edge t gives `d_valid` = 1 and valid data from edge t onward, i.e. visible in cycle t+1.
- Throughput: 1 word/cycle per channel when the consumer holds `d_ready=1` continuously.
- No combinational path from `i` to `d`.
- Combinational paths from `d_ready`, `s`, `bc` to `in_ready` are allowed. `in_valid` must not depend on `in_ready`.
- Producer must hold `i`/`s`/`bc` stable while `in_valid=1 && in_ready=0`. Consumers may deassert `d_ready` at any time.

## Structure
- Shared package `demux_pkg`:
  - `N_MAX`=16 and `W_MAX`=32, used for range checks.
  - A channel-state typedef of {data, valid}.
- Sub-module `demux_chan` (parameter `W`): one-deep register with a `load`/`din` input and a `d`/`d_valid`/`d_ready` output. It exposes `free` and is instantiated N times by a generate loop.
- Top level contains the select decode, broadcast logic, `in_ready` mux and the `err` register.

## Test plan
- Reset then single unicasts (N=4, W=8):
  - `s`=2, `i`=0xA5, `in_valid`=1 with all `d_ready`=1 -> next cycle `d_valid`=4'b0100 and `d[23:16]`=0xA5.
  - Then 4'b0000 after the drain.
- Backpressure: hold `d_ready[1]`=0, send 0x11 then 0x22 to `s`=1:
  - Second word sees `in_ready`=0; `d[15:8]` stays 0x11.
  - A unicast 0x33 to `s`=3 is still accepted.
  - Raise `d_ready[1]`: 0x22 loads in the same cycle 0x11 drains; `d_valid[1]` stays 1.
- Broadcast: `bc`=1, `i`=0x5A with `d_ready[0]`=0 and channel 0 full -> `in_ready`=0. Release `d_ready[0]` -> all four slices = 0x5A and `d_valid`=4'hF.
- Out-of-range (N=3, SW=2):
  - `s`=3, `i`=0x7F -> `in_ready`=1, `d_valid` unchanged, `err`=1.
  - Assert `err_clr` alone -> `err`=0.
  - `err_clr` together with another `s`=3 transfer -> `err` stays 1.
- Streaming: `d_ready[0]`=1, 8 back-to-back words 0..7 on `s`=0 -> 8 consecutive cycles with `d_valid[0]`=1 carrying 0..7 in order.
- Reset mid-stream: `rst`=1 while `d_valid`=4'b1011 -> next cycle `d_valid`=0, `d`=0, `err`=0, with `in_ready`=0 throughout the reset cycle.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared limits and channel-state type for the registered demux.
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int N_MAX = 16;
    localparam int W_MAX = 32;

    // Storage is sized for the widest legal channel; narrower channels use the low bits.
    typedef struct packed {
        logic [W_MAX-1:0] data;
        logic             valid;
    } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/demux_chan.sv
`default_nettype none
// ============================================================================
// Module   : demux_chan
// Brief    : One-deep output holding register with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module demux_chan
    import demux_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] d,
    output logic         d_valid,
    input  logic         d_ready,
    output logic         free
);

    chan_state_t r_state;

    // A full channel is still free when its consumer drains it this cycle.
    assign free    = !r_state.valid || d_ready;
    assign d       = r_state.data[W-1:0];
    assign d_valid = r_state.valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
        end else if (load) begin
            r_state.data  <= W_MAX'(din);
            r_state.valid <= 1'b1;
        end else if (d_ready) begin
            r_state.valid <= 1'b0;
        end
    end

    if (W < W_MAX) begin : g_pad
        logic [W_MAX-W-1:0] w_unused_pad;
        assign w_unused_pad = r_state.data[W_MAX-1:W];
    end

endmodule
`default_nettype wire

// File: rtl/demux1ton_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux1ton_reg
// Brief    : Registered 1-to-N demux with per-channel buffering, broadcast
//            and a sticky out-of-range select error.
// Revision : 1.0 - initial release
// ============================================================================
module demux1ton_reg
    import demux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 1,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   i,
    input  logic [SW-1:0]  s,
    input  logic           bc,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N*W-1:0] d,
    output logic [N-1:0]   d_valid,
    input  logic [N-1:0]   d_ready,
    output logic           err,
    input  logic           err_clr
);

    if (N < 2 || N > N_MAX) begin : g_bad_n
        $error("demux1ton_reg: N out of range");
    end
    if (W < 1 || W > W_MAX) begin : g_bad_w
        $error("demux1ton_reg: W out of range");
    end

    logic [N-1:0] w_sel;
    logic [N-1:0] w_free;
    logic [N-1:0] w_load;
    logic         w_in_range;
    logic         w_in_ready;
    logic         w_xfer;
    logic         w_err_set;
    logic         r_err;

    // One-hot decode; an all-zero result marks a select beyond the last channel.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < N; k++) begin
            w_sel[k] = (s == SW'(k));
        end
    end

    assign w_in_range = |w_sel;

    always_comb begin
        w_in_ready = 1'b0;
        if (rst) begin
            w_in_ready = 1'b0;
        end else if (bc) begin
            w_in_ready = &w_free;
        end else if (w_in_range) begin
            w_in_ready = |(w_sel & w_free);
        end else begin
            w_in_ready = 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign w_xfer    = in_valid && w_in_ready;
    assign w_load    = w_xfer ? (bc ? {N{1'b1}} : w_sel) : {N{1'b0}};
    assign w_err_set = w_xfer && !bc && !w_in_range;

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;

    for (genvar k = 0; k < N; k++) begin : g_chan
        demux_chan #(
            .W (W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .load    (w_load[k]),
            .din     (i),
            .d       (d[k*W +: W]),
            .d_valid (d_valid[k]),
            .d_ready (d_ready[k]),
            .free    (w_free[k])
        );
    end

endmodule
`default_nettype wire
